// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds NCH-channel frames from a sync-marked serial sample stream (CLK/RST, in_valid/in_sync/in_data in; out_data/out_valid/err/frame_cnt out)
module tdm_demux #(
  parameter int NCH = 2,
  parameter int W = 1,
  parameter int IW = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [W-1:0]     in_data,
  output logic [NCH*W-1:0] out_data,
  output logic             out_valid,
  output logic             err,
  output logic [7:0]       frame_cnt
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  logic [0:0] state;
  logic [IW-1:0] idx;
  logic [IW-1:0] wr_idx;
  logic [(NCH-1)*W-1:0] sh;
  logic wr_en;
  logic done;
  always_comb begin
    done = in_valid & ~in_sync & (state == COLLECT) & (idx == LAST);
    wr_en = in_valid & (in_sync | ((state == COLLECT) & (idx != LAST)));
    wr_idx = in_sync ? '0 : idx;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HUNT;
      idx <= '0;
      sh <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      out_valid <= done;
      err <= in_valid & (in_sync ? (state == COLLECT) : (state == HUNT));
      for (int k = 0; k < NCH - 1; k++)
        if (wr_en && wr_idx == IW'(k)) sh[k*W +: W] <= in_data;
      if (in_valid && in_sync) begin
        idx <= IW'(1);
        state <= COLLECT;
      end else if (done) begin
        out_data <= {in_data, sh};
        frame_cnt <= frame_cnt + 8'd1;
        idx <= '0;
        state <= HUNT;
      end else if (wr_en) begin
        idx <= idx + IW'(1);
      end
    end
  end
endmodule
